// File: rtl/uart_pkg.sv
// UART shared definitions.
// State encodings and oversampling constants.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] TCNT_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TCNT_MID  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator.
// One-cycle tick every max(div_i,1) clocks.
module uart_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] div_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;
  logic [DIV_WIDTH-1:0] lim;

  // Wrap on >= so a smaller divisor never strands the count
  always_comb begin
    lim    = '0;
    if (div_i != '0) lim = div_i - DIV_WIDTH'(1);
    tick_o = (cnt_q >= lim);
    cnt_d  = tick_o ? '0 : cnt_q + DIV_WIDTH'(1);
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_param.sv
// Parameterised UART with 16x oversampling.
// TX/RX FSMs share one tick generator.
module uart_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
  input  logic                 loopback,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_done,
  output logic                 txd,
  input  logic                 rxd,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic tick;

  uart_tick_gen #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_tick (
    .clk   (clk),
    .rst_n (reset),
    .div_i (baud_div),
    .tick_o(tick)
  );

  tx_state_e            tx_st_q, tx_st_d;
  logic                 tx_go_q, tx_go_d;
  logic [3:0]           tx_tc_q, tx_tc_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_pen_q, tx_pen_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_two_q, tx_two_d;
  logic                 tx_done_q, tx_done_d;

  // TX state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st_q   <= TX_IDLE;
      tx_go_q   <= 1'b0;
      tx_tc_q   <= '0;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      tx_pen_q  <= 1'b0;
      tx_par_q  <= 1'b0;
      tx_two_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      tx_st_q   <= tx_st_d;
      tx_go_q   <= tx_go_d;
      tx_tc_q   <= tx_tc_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      tx_pen_q  <= tx_pen_d;
      tx_par_q  <= tx_par_d;
      tx_two_q  <= tx_two_d;
      tx_done_q <= tx_done_d;
    end
  end

  // TX next state; start bit waits for the first tick
  always_comb begin
    tx_st_d   = tx_st_q;
    tx_go_d   = tx_go_q;
    tx_tc_d   = tx_tc_q;
    tx_bit_d  = tx_bit_q;
    tx_sh_d   = tx_sh_q;
    tx_pen_d  = tx_pen_q;
    tx_par_d  = tx_par_q;
    tx_two_d  = tx_two_q;
    tx_done_d = 1'b0;
    if (tx_st_q == TX_IDLE) begin
      if (tx_valid) begin
        tx_st_d  = TX_START;
        tx_go_d  = 1'b0;
        tx_tc_d  = '0;
        tx_bit_d = '0;
        tx_sh_d  = tx_data;
        tx_pen_d = parity_en;
        tx_par_d = (^tx_data) ^ parity_odd;
        tx_two_d = two_stop;
      end
    end else if (tick) begin
      if (tx_st_q == TX_START && !tx_go_q) begin
        tx_go_d = 1'b1;
      end else if (tx_tc_q != TCNT_LAST) begin
        tx_tc_d = tx_tc_q + 4'd1;
      end else begin
        tx_tc_d = '0;
        unique case (tx_st_q)
          TX_START: tx_st_d = TX_DATA;
          TX_DATA: begin
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 3'd1;
            if (tx_bit_q == LAST_BIT) begin
              tx_bit_d = '0;
              tx_st_d  = tx_pen_q ? TX_PARITY
                                  : TX_STOP;
            end
          end
          TX_PARITY: tx_st_d = TX_STOP;
          TX_STOP: begin
            if (tx_two_q && tx_bit_q == '0) begin
              tx_bit_d = 3'd1;
            end else begin
              tx_st_d   = TX_IDLE;
              tx_done_d = 1'b1;
            end
          end
          default: tx_st_d = TX_IDLE;
        endcase
      end
    end
  end

  // Serial line decode from TX state
  always_comb begin
    txd = 1'b1;
    unique case (tx_st_q)
      TX_START:  txd = ~tx_go_q;
      TX_DATA:   txd = tx_sh_q[0];
      TX_PARITY: txd = tx_par_q;
      default:   txd = 1'b1;
    endcase
  end

  assign tx_ready = (tx_st_q == TX_IDLE);
  assign tx_done  = tx_done_q;

  logic [2:0] sync_q, sync_d;
  logic       rx_in;
  logic       rx_prev;

  assign sync_d  = {sync_q[1:0], loopback ? txd : rxd};
  assign rx_in   = sync_q[1];
  assign rx_prev = sync_q[2];

  // Two-flop synchroniser plus edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  rx_state_e            rx_st_q, rx_st_d;
  logic [3:0]           rx_tc_q, rx_tc_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic                 rx_pe_q, rx_pe_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  // RX state and holding registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_st_q    <= RX_IDLE;
      rx_tc_q    <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_pe_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_st_q    <= rx_st_d;
      rx_tc_q    <= rx_tc_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_pe_q    <= rx_pe_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  // RX next state; new word beats a same-cycle handshake
  always_comb begin
    rx_st_d    = rx_st_q;
    rx_tc_d    = rx_tc_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_pe_d    = rx_pe_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
      ovr_d      = 1'b0;
    end
    unique case (rx_st_q)
      RX_IDLE: begin
        rx_tc_d = '0;
        if (rx_prev && !rx_in) rx_st_d = RX_START;
      end
      RX_START: begin
        if (tick) begin
          rx_tc_d = rx_tc_q + 4'd1;
          if (rx_tc_q == TCNT_MID) begin
            rx_tc_d  = '0;
            rx_bit_d = '0;
            rx_pe_d  = 1'b0;
            rx_st_d  = rx_in ? RX_IDLE : RX_DATA;
          end
        end
      end
      default: begin
        if (tick) begin
          rx_tc_d = rx_tc_q + 4'd1;
          if (rx_tc_q == TCNT_LAST) begin
            rx_tc_d = '0;
            unique case (rx_st_q)
              RX_DATA: begin
                rx_sh_d  = {rx_in, rx_sh_q[DATA_BITS-1:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == LAST_BIT) begin
                  rx_st_d = parity_en ? RX_PARITY
                                      : RX_STOP;
                end
              end
              RX_PARITY: begin
                rx_pe_d = rx_in ^ (^rx_sh_q) ^ parity_odd;
                rx_st_d = RX_STOP;
              end
              default: begin
                rx_st_d    = RX_IDLE;
                rx_data_d  = rx_sh_q;
                perr_d     = rx_pe_q;
                ferr_d     = ~rx_in;
                rx_valid_d = 1'b1;
                if (rx_valid_q && !rx_ready) ovr_d = 1'b1;
              end
            endcase
          end
        end
      end
    endcase
  end

  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_param.sv
// Self-checking bench for uart_param.
// Frames modelled as bit lists, compared per scenario.
module tb_uart_param;

  localparam int DB = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] baud_div;
  logic          parity_en, parity_odd;
  logic          two_stop, loopback;
  logic          tx_valid;
  logic [DB-1:0] tx_data;
  logic          tx_ready, tx_done, txd;
  logic          rxd;
  logic          rx_valid, rx_ready;
  logic [DB-1:0] rx_data;
  logic          parity_err, frame_err, overrun;

  int checks = 0;
  int errors = 0;

  uart_param #(
    .DATA_BITS(DB),
    .DIV_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_div  (baud_div),
    .parity_en (parity_en),
    .parity_odd(parity_odd),
    .two_stop  (two_stop),
    .loopback  (loopback),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .tx_done   (tx_done),
    .txd       (txd),
    .rxd       (rxd),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // reference frame: list of line levels, one per bit
  logic exp_bits[0:15];
  int   exp_len;

  function automatic void build_frame(
    input logic [7:0] d, input logic pen,
    input logic odd, input logic two);
    exp_len = 0;
    exp_bits[exp_len] = 1'b0;
    exp_len++;
    for (int i = 0; i < DB; i++) begin
      exp_bits[exp_len] = d[i];
      exp_len++;
    end
    if (pen) begin
      exp_bits[exp_len] = (^d) ^ odd;
      exp_len++;
    end
    exp_bits[exp_len] = 1'b1;
    exp_len++;
    if (two) begin
      exp_bits[exp_len] = 1'b1;
      exp_len++;
    end
  endfunction

  logic       obs_s[0:15];
  logic       obs_m[0:15];
  logic       obs_e[0:15];
  int         fall_idx, done_off, done_cnt;
  bit         rdy_bad, rx_seen;
  logic [7:0] rx_cap;
  logic       rx_pe, rx_fe;

  // send one frame and record txd at bit start/mid/end
  task automatic run_tx(
    input logic [7:0] d, input logic pen,
    input logic odd, input logic two, input bit scr);
    int dv, bp, tot, k, r;
    dv = (baud_div == '0) ? 1 : int'(baud_div);
    bp = 16 * dv;
    tot = exp_len * bp;
    for (int i = 0; i < 16; i++) begin
      obs_s[i] = 1'bx;
      obs_m[i] = 1'bx;
      obs_e[i] = 1'bx;
    end
    fall_idx = -1;
    done_off = -1;
    done_cnt = 0;
    rdy_bad = 0;
    rx_seen = 0;
    @(negedge clk);
    tx_data = d;
    parity_en = pen;
    parity_odd = odd;
    two_stop = two;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    if (scr) begin
      tx_data = ~d;
      parity_en = ~pen;
      parity_odd = ~odd;
      two_stop = ~two;
    end
    for (int i = 1; i <= 2 * dv + 10; i++) begin
      if (i > 1) @(negedge clk);
      if (txd === 1'b0) begin
        fall_idx = i;
        break;
      end
    end
    if (fall_idx < 0) return;
    for (int o = 0; o <= tot + 2; o++) begin
      if (o > 0) @(negedge clk);
      k = o / bp;
      r = o % bp;
      if (k < 16) begin
        if (r == 0) obs_s[k] = txd;
        if (r == bp / 2) obs_m[k] = txd;
        if (r == bp - 1) obs_e[k] = txd;
      end
      if (o < tot && tx_ready !== 1'b0) rdy_bad = 1;
      if (tx_done === 1'b1) begin
        done_cnt++;
        if (done_off < 0) done_off = o;
      end
      if (rx_valid === 1'b1 && !rx_seen) begin
        rx_seen = 1;
        rx_cap = rx_data;
        rx_pe = parity_err;
        rx_fe = frame_err;
      end
    end
  endtask

  // drive exp_bits onto rxd, then one idle bit
  task automatic drive_rx(input int bp);
    for (int k = 0; k < exp_len; k++) begin
      rxd = exp_bits[k];
      repeat (bp) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (bp) @(negedge clk);
  endtask

  task automatic clear_rx();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    baud_div = 16'd4;
    parity_en = 0;
    parity_odd = 0;
    two_stop = 0;
    loopback = 0;
    tx_valid = 0;
    tx_data = '0;
    rxd = 1'b1;
    rx_ready = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({txd, tx_ready, tx_done} !== 3'b110) begin
      errors++;
      $display("FAIL reset_tx got %b want 110",
               {txd, tx_ready, tx_done});
    end
    checks++;
    if ({rx_valid, parity_err, frame_err, overrun}
        !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rx_flags got %b want 0000",
               {rx_valid, parity_err, frame_err, overrun});
    end
    checks++;
    if (rx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_data got %h want 00", rx_data);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_a5();
    logic [9:0] seq;
    seq = 10'b1101001010;
    loopback = 0;
    baud_div = 16'd4;
    build_frame(8'hA5, 0, 0, 0);
    run_tx(8'hA5, 0, 0, 0, 1);
    parity_en = 0;
    parity_odd = 0;
    two_stop = 0;
    checks++;
    if (fall_idx < 2 || fall_idx > 5) begin
      errors++;
      $display("FAIL a5_first_tick got %0d want 2..5",
               fall_idx);
    end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (obs_m[k] !== seq[k] ||
          {obs_s[k], obs_e[k]} !== {2{exp_bits[k]}}) begin
        errors++;
        $display("FAIL a5_bit%0d got %b%b%b want %b",
                 k, obs_s[k], obs_m[k], obs_e[k], seq[k]);
      end
    end
    checks++;
    if (done_off !== 640 || done_cnt !== 1) begin
      errors++;
      $display("FAIL a5_done got off %0d cnt %0d want 640 1",
               done_off, done_cnt);
    end
    checks++;
    if (rdy_bad || tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL a5_ready got bad=%0d end=%b want 0 1",
               rdy_bad, tx_ready);
    end
  endtask

  task automatic test_loopback_3c();
    loopback = 1;
    baud_div = 16'd4;
    build_frame(8'h3C, 1, 0, 0);
    run_tx(8'h3C, 1, 0, 0, 0);
    checks++;
    if (obs_m[9] !== 1'b0) begin
      errors++;
      $display("FAIL lb_parity_bit got %b want 0", obs_m[9]);
    end
    checks++;
    if (!rx_seen || rx_cap !== 8'h3C ||
        rx_pe !== 1'b0 || rx_fe !== 1'b0) begin
      errors++;
      $display("FAIL lb_rx got seen%0d %h pe%b fe%b want 3c 0 0",
               rx_seen, rx_cap, rx_pe, rx_fe);
    end
    clear_rx();
  endtask

  task automatic test_random_loopback();
    logic [7:0] d;
    logic pen, odd, two;
    int divs[5];
    int dv;
    divs = '{0, 1, 2, 3, 5};
    loopback = 1;
    for (int n = 0; n < 5; n++) begin
      d = 8'($urandom);
      pen = 1'($urandom);
      odd = 1'($urandom);
      two = 1'($urandom);
      dv = divs[$urandom_range(0, 4)];
      baud_div = 16'd60;
      repeat (25) @(negedge clk);
      baud_div = 16'(dv);
      if (dv == 0) dv = 1;
      build_frame(d, pen, odd, two);
      run_tx(d, pen, odd, two, 0);
      checks++;
      for (int k = 0; k < exp_len; k++) begin
        if ({obs_s[k], obs_m[k], obs_e[k]}
            !== {3{exp_bits[k]}}) begin
          errors++;
          $display("FAIL rnd%0d_bit%0d got %b%b%b want %b",
                   n, k, obs_s[k], obs_m[k], obs_e[k],
                   exp_bits[k]);
          break;
        end
      end
      checks++;
      if (done_off !== exp_len * 16 * dv) begin
        errors++;
        $display("FAIL rnd%0d_done got %0d want %0d",
                 n, done_off, exp_len * 16 * dv);
      end
      checks++;
      if (!rx_seen || rx_cap !== d ||
          rx_pe !== 1'b0 || rx_fe !== 1'b0) begin
        errors++;
        $display("FAIL rnd%0d_rx got %0d %h %b%b want %h 00",
                 n, rx_seen, rx_cap, rx_pe, rx_fe, d);
      end
      clear_rx();
    end
    parity_en = 0;
    parity_odd = 0;
    two_stop = 0;
    baud_div = 16'd4;
  endtask

  task automatic test_parity_err();
    loopback = 0;
    baud_div = 16'd4;
    parity_en = 1;
    parity_odd = 0;
    build_frame(8'h55, 1, 0, 0);
    exp_bits[9] = ~exp_bits[9];
    drive_rx(64);
    checks++;
    if ({rx_valid, parity_err, frame_err} !== 3'b110 ||
        rx_data !== 8'h55) begin
      errors++;
      $display("FAIL par_err got v%b pe%b fe%b %h want 110 55",
               rx_valid, parity_err, frame_err, rx_data);
    end
    clear_rx();
    parity_en = 0;
  endtask

  task automatic test_frame_err();
    loopback = 0;
    baud_div = 16'd4;
    build_frame(8'h9A, 0, 0, 0);
    exp_bits[9] = 1'b0;
    drive_rx(64);
    checks++;
    if ({rx_valid, frame_err, parity_err} !== 3'b110 ||
        rx_data !== 8'h9A) begin
      errors++;
      $display("FAIL frm_err got v%b fe%b pe%b %h want 110 9a",
               rx_valid, frame_err, parity_err, rx_data);
    end
    clear_rx();
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL frm_clear got %b want 0", rx_valid);
    end
    build_frame(8'h12, 0, 0, 0);
    drive_rx(64);
    checks++;
    if ({rx_valid, frame_err, parity_err} !== 3'b100 ||
        rx_data !== 8'h12) begin
      errors++;
      $display("FAIL frm_next got v%b fe%b pe%b %h want 100 12",
               rx_valid, frame_err, parity_err, rx_data);
    end
    clear_rx();
  endtask

  task automatic test_false_start();
    loopback = 0;
    baud_div = 16'd4;
    rxd = 1'b0;
    repeat (5 * 4) @(negedge clk);
    rxd = 1'b1;
    repeat (40 * 4) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL false_start got %b want 0", rx_valid);
    end
    build_frame(8'hE7, 0, 0, 0);
    drive_rx(64);
    checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hE7) begin
      errors++;
      $display("FAIL after_false got %b %h want 1 e7",
               rx_valid, rx_data);
    end
    clear_rx();
  endtask

  task automatic test_overrun();
    loopback = 0;
    baud_div = 16'd4;
    rx_ready = 0;
    build_frame(8'h01, 0, 0, 0);
    drive_rx(64);
    build_frame(8'h02, 0, 0, 0);
    drive_rx(64);
    checks++;
    if ({rx_valid, overrun} !== 2'b11 ||
        rx_data !== 8'h02) begin
      errors++;
      $display("FAIL overrun got v%b o%b %h want 11 02",
               rx_valid, overrun, rx_data);
    end
    clear_rx();
    checks++;
    if ({rx_valid, overrun} !== 2'b00) begin
      errors++;
      $display("FAIL ovr_clear got %b%b want 00",
               rx_valid, overrun);
    end
  endtask

  task automatic test_reset_mid_tx();
    loopback = 1;
    baud_div = 16'd4;
    @(negedge clk);
    tx_data = 8'hF0;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (200) @(negedge clk);
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy got %b want 0", tx_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({txd, tx_ready} !== 2'b11) begin
      errors++;
      $display("FAIL mid_reset got %b%b want 11",
               txd, tx_ready);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    build_frame(8'hC3, 1, 1, 0);
    run_tx(8'hC3, 1, 1, 0, 0);
    checks++;
    if (!rx_seen || rx_cap !== 8'hC3 || rx_pe !== 1'b0 ||
        rx_fe !== 1'b0 || done_off !== exp_len * 64) begin
      errors++;
      $display("FAIL post_reset got %0d %h %b%b %0d want c3",
               rx_seen, rx_cap, rx_pe, rx_fe, done_off);
    end
    clear_rx();
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_tx_a5();
    test_loopback_3c();
    test_random_loopback();
    test_parity_err();
    test_frame_err();
    test_false_start();
    test_overrun();
    test_reset_mid_tx();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_param.md
UART_PARAM -- requirements
Module: uart_param

Interface
REQ-001 The block SHALL have the following parameters:
- DATA_BITS, 8, frame data width; legal range 5..8.
- DIV_WIDTH, 16, width of the baud divisor.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 The block SHALL have the following ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- baud_div  in  DIV_WIDTH  clk cycles per 16x oversample tick.
- parity_en  in  1  parity bit present.
- parity_odd  in  1  1 = odd parity, 0 = even.
- two_stop  in  1  TX sends 2 stop bits.
- loopback  in  1  route internal TX line to the RX path.
- tx_valid  in  1  TX data offered.
- tx_data  in  DATA_BITS  byte to send.
- tx_ready  out  1  TX idle, can accept.
- tx_done  out  1  one-cycle pulse at end of last stop bit.
- txd  out  1  serial output.
- rxd  in  1  serial input (asynchronous).
- rx_valid  out  1  received word held.
- rx_ready  in  1  consumer takes word.
- rx_data  out  DATA_BITS  received word.
- parity_err  out  1  parity mismatch, qualified by rx_valid.
- frame_err  out  1  stop bit sampled 0, qualified by rx_valid.
- overrun  out  1  sticky: word lost; cleared by rx_valid && rx_ready.

Function
REQ-004 The tick generator SHALL assert a one-cycle tick every max(baud_div,1) cycles.
REQ-005 The tick counter SHALL wrap on count >= baud_div-1, so a mid-run divisor decrease never stalls it.
REQ-006 Every bit period, TX and RX, SHALL be exactly 16 ticks.
REQ-007 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-008 tx_ready SHALL be 1 only in IDLE.
REQ-009 A transfer SHALL be accepted on tx_valid && tx_ready; tx_ready SHALL be 0 on the next cycle.
REQ-010 On acceptance, tx_data, parity_en, parity_odd and two_stop SHALL be latched; later changes SHALL NOT affect the frame in progress.
REQ-011 TX frame SHALL be: start 0, DATA_BITS bits LSB first, optional parity bit, then 1 or 2 stop bits of 1.
REQ-012 The parity bit SHALL be XOR of the data bits, inverted when parity_odd is 1.
REQ-013 The first bit SHALL begin on the first tick after acceptance.
REQ-014 txd SHALL be 1 whenever the TX FSM is idle.
REQ-015 tx_done SHALL pulse for one cycle, in the cycle the FSM returns to IDLE.
REQ-016 The RX input SHALL be the loopback mux output (internal TX line when loopback is 1, else rxd), passed through a 2-flop synchroniser reset to 1.
REQ-017 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE, a synchronised 1->0 transition SHALL enter START.
REQ-019 In START, the line SHALL be sampled after 8 ticks; if it is 1, the start is false and the FSM SHALL return to IDLE with no output.
REQ-020 After a valid start, each later bit SHALL be sampled 16 ticks after the previous sample (mid-bit).
REQ-021 RX SHALL check exactly one stop bit.
REQ-022 At the stop-bit sample, RX SHALL load rx_data, parity_err and frame_err, set rx_valid, and return to IDLE in the same cycle (back-to-back frames allowed).
REQ-023 parity_err SHALL be 0 when parity_en is 0.
REQ-024 rx_valid SHALL stay high until rx_valid && rx_ready.
REQ-025 If a frame completes while rx_valid is 1, the holding register SHALL be overwritten and overrun SHALL be set.
REQ-026 If a frame completes in the same cycle as a rx_ready handshake, the new word SHALL win: rx_valid stays 1 and overrun is not set.

Reset
REQ-027 While reset = 0, all state SHALL go to: FSMs IDLE, counters 0, txd 1, tx_ready 1, tx_done 0, rx_valid 0, rx_data 0, parity_err 0, frame_err 0, overrun 0, synchroniser 1.
REQ-028 Reset mid-frame SHALL abort the frame; the first frame after reset release SHALL be clean.

Structure
REQ-029 Package uart_pkg SHALL hold the TX and RX state enums and the constant OVERSAMPLE = 16.
REQ-030 The tick generator SHALL be a sub-module uart_tick_gen, shared by TX and RX.

Verification
REQ-031 The bench SHALL cover:
- baud_div=4, 8N1, send 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each bit 64 clk; tx_done 640 clk after first tick; tx_ready low throughout.
- loopback=1, even parity, send 0x3C -> rx_data=0x3C, parity bit 0, parity_err=0, frame_err=0.
- rxd driven with 0x55, parity_en=1, even, wrong parity bit -> rx_valid with parity_err=1.
- rxd frame with stop bit 0 -> frame_err=1; a following frame 0x12 is received correctly.
- rxd low for 5 ticks only -> no rx_valid, FSM back in IDLE.
- two frames 0x01, 0x02 with rx_ready=0 -> rx_data=0x02, overrun=1; rx_ready pulse clears rx_valid and overrun; reset asserted mid-TX-frame -> txd=1, tx_ready=1 immediately.
